// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, delayed syncs
// and line/frame strobes for the chess board renderer.
module vga_timing_generator #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       is_in_display_area,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [9:0]       h_cnt_reg, h_cnt_next;
    logic [9:0]       v_cnt_reg, v_cnt_next;
    logic             line_start_reg, line_start_next;
    logic             frame_start_reg, frame_start_next;
    logic             h_last, v_last;
    logic             hsync_raw, vsync_raw;

    assign pixel_tick = (div_reg == DIV_LAST);
    assign h_last     = (h_cnt_reg == H_LAST);
    assign v_last     = (v_cnt_reg == V_LAST);

    always_comb begin
        div_next         = div_reg + 1'b1;
        h_cnt_next       = h_cnt_reg;
        v_cnt_next       = v_cnt_reg;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;
        if (pixel_tick) begin
            div_next = '0;
            if (h_last) begin
                h_cnt_next      = '0;
                v_cnt_next      = v_last ? 10'd0 : v_cnt_reg + 10'd1;
                line_start_next = 1'b1;
                frame_start_next = v_last;
            end else begin
                h_cnt_next = h_cnt_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg         <= '0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= div_next;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign h_cnt       = h_cnt_reg;
    assign v_cnt       = v_cnt_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

    assign is_in_display_area = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign hsync_raw = !((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END));
    assign vsync_raw = !((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END));

    // Sync delay keeps the pins aligned with the renderer's registered colour.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync = hsync_raw;
            assign vsync = vsync_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_reg;
            logic [SYNC_DELAY-1:0] vs_pipe_reg;
            for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
                logic hs_in, vs_in;
                if (gi == 0) begin : g_first
                    assign hs_in = hsync_raw;
                    assign vs_in = vsync_raw;
                end else begin : g_rest
                    assign hs_in = hs_pipe_reg[gi-1];
                    assign vs_in = vs_pipe_reg[gi-1];
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        hs_pipe_reg[gi] <= 1'b1;
                        vs_pipe_reg[gi] <= 1'b1;
                    end else begin
                        hs_pipe_reg[gi] <= hs_in;
                        vs_pipe_reg[gi] <= vs_in;
                    end
                end
            end
            assign hsync = hs_pipe_reg[SYNC_DELAY-1];
            assign vsync = vs_pipe_reg[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates the 640x480 @ 60 Hz VGA raster timing that drives the chess board renderer. It divides the 100 MHz system clock down to a pixel rate and runs the horizontal and vertical pixel counters. It produces `h_cnt`, `v_cnt` and `is_in_display_area`, which feed the renderer. It also produces the hsync/vsync pins, delayed so they line up with the renderer's registered colour output, plus line/frame strobes for board-state and mouse logic.

## Interface
- `CLK_DIV`, 4 — system clocks per pixel; must be ≥ 2.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48 — horizontal timing, in pixels.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33 — vertical timing, in lines.
- `SYNC_DELAY`, 1 — clk cycles of delay applied to hsync/vsync; range 0..7.

Ports:
- `clk` input 1 — 100 MHz system clock.
- `rst` input 1 — asynchronous, active-low reset.
- `h_cnt` output 10 — current pixel column, 0..H_TOTAL-1.
- `v_cnt` output 10 — current line, 0..V_TOTAL-1.
- `is_in_display_area` output 1 — high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- `hsync` output 1 — horizontal sync, active-low, delayed.
- `vsync` output 1 — vertical sync, active-low, delayed.
- `pixel_tick` output 1 — one-clk pulse on the last clk of each pixel.
- `line_start` output 1 — one-clk pulse during the first clk of pixel h_cnt=0.
- `frame_start` output 1 — one-clk pulse during the first clk of pixel (0,0).

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (div == CLK_DIV-1), decoded combinationally.
- On a clk edge where `pixel_tick` is high:
  - If h_cnt == H_TOTAL-1, h_cnt goes to 0 and v_cnt advances.
  - Otherwise h_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0.
- Both counters hold when `pixel_tick` is low. Counter widths are 10 bits; no overflow is possible with the legal parameters.
- Raw sync, combinational from the counters:
  - hsync_raw is low while H_VISIBLE+H_FRONT ≤ h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync_raw is low while V_VISIBLE+V_FRONT ≤ v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- hsync/vsync are produced by passing the raw sync through a SYNC_DELAY-stage clk shift register. With SYNC_DELAY = 0, raw sync is output directly.
- `line_start` is a register set on the clk edge where h_cnt changes to 0, and cleared on the next clk edge.
- `frame_start` is a register set on the clk edge where (h_cnt, v_cnt) changes to (0,0), and cleared on the next clk edge. It coincides with the `line_start` of line 0.
- `is_in_display_area` is combinational from the counter registers.

## Timing
- Values during reset (`rst` low):
  - div, h_cnt and v_cnt = 0.
  - `is_in_display_area` = 1.
  - hsync, vsync and every shift-register stage = 1 (deasserted).
  - `line_start`, `frame_start` = 0; `pixel_tick` = 0 because div = 0.
- No `line_start` or `frame_start` pulse is emitted on reset release. The first pulses come at the first wrap.
- After reset release (edge 1 = first rising edge with `rst` high):
  - `pixel_tick` is first high between edges 3 and 4.
  - h_cnt = 1 after edge 4.
  - In general, h_cnt = n after edge 4n, for n < H_TOTAL.
- Periods: line = H_TOTAL·CLK_DIV = 3200 clk; frame = 3200·525 = 1,680,000 clk.
- hsync/vsync lag the counter-derived raw sync by exactly SYNC_DELAY clk. This matches the renderer's one-register colour path at the default of 1.
- Reset mid-frame clears all state asynchronously in the same cycle; no partial pulse survives.
- Simultaneous h and v wrap, at (H_TOTAL-1, V_TOTAL-1), happen in a single edge to (0,0). `line_start` and `frame_start` are then both high for the following clk.

## Test plan
- Reset hold, then release:
  - During reset: h_cnt = v_cnt = 0, hsync = vsync = 1, `is_in_display_area` = 1, no strobes.
  - After release: `pixel_tick` is high every 4th clk; h_cnt = 1 after edge 4 and 2 after edge 8.
- Run one full line:
  - `is_in_display_area` falls when h_cnt reaches 640.
  - hsync goes low 1 clk after h_cnt becomes 656 and returns high 1 clk after h_cnt becomes 752.
  - h_cnt wraps 799→0 with v_cnt 0→1 and a single-clk `line_start`; the line period is 3200 clk.
- Run one full frame:
  - vsync is low exactly while v_cnt ∈ {490, 491}, offset by 1 clk.
  - At (799,524)→(0,0), `frame_start` and `line_start` pulse together for one clk.
  - The next `frame_start` comes 1,680,000 clk later.
- Assert `rst` low at h_cnt = 700, v_cnt = 491, while hsync and vsync are both low:
  - Outputs immediately return to reset values.
  - After release, counting restarts from (0,0) with no strobe.
- Rebuild with SYNC_DELAY = 0 and CLK_DIV = 2:
  - hsync falls in the same clk in which h_cnt becomes 656.
  - The line period is 1600 clk.
